// File: rtl/serial_adder_ctrl.sv
// Serial add/subtract sequencer: one shared 2-bit ripple slice processes WIDTH
// bits over WIDTH/2 RUN cycles behind a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], ci);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] op_a_r, op_b_r, sum_r;
  logic             carry_r, busy_r, done_r, cout_r, ovf_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       lo_s, hi_s;
  logic [WIDTH+1:0] sum_ext_s, op_a_ext_s, op_b_ext_s;

  // Shared 2-bit slice; lo_s[1] is the carry into bit 1 (into the MSB on the last digit).
  always_comb begin
    lo_s       = full_add(op_a_r[0], op_b_r[0], carry_r);
    hi_s       = full_add(op_a_r[1], op_b_r[1], lo_s[1]);
    sum_ext_s  = {hi_s[0], lo_s[0], sum_r};
    op_a_ext_s = {2'b00, op_a_r};
    op_b_ext_s = {2'b00, op_b_r};
  end

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          sum_r   <= sum_ext_s[WIDTH+1:2];
          op_a_r  <= op_a_ext_s[WIDTH+1:2];
          op_b_r  <= op_b_ext_s[WIDTH+1:2];
          carry_r <= hi_s[1];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_DIGIT) begin
            cout_r  <= hi_s[1];
            ovf_r   <= hi_s[1] ^ lo_s[1];
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances, directed
// vectors with hand-computed results and done-cycle timing.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = 2'b00, b2 = 2'b00;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  s;
    logic        c;
    logic        o;
    logic [31:0] due;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(1'b0), .cin(cin2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o, input int due);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o;
    e.due = 32'(due);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check("w8_sum", 32'(sum), 32'(e.s));
        check("w8_cout", 32'(cout), 32'(e.c));
        check("w8_ovf", 32'(ovf), 32'(e.o));
        check("w8_done_cycle", 32'(cyc), e.due);
        check("w8_busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        check("w2_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("w2_sum", 32'(sum2), 32'(e.s));
        check("w2_cout", 32'(cout2), 32'(e.c));
        check("w2_ovf", 32'(ovf2), 32'(e.o));
        check("w2_done_cycle", 32'(cyc), e.due);
      end
    end
  end

  task automatic drain8();
    for (int i = 0; i < 30 && q8.size() != 0; i++) @(negedge clk);
    #1;
    if (q8.size() != 0) begin
      check("w8_done_timeout", 32'(q8.size()), 32'd0);
      q8.delete();
    end
  endtask

  task automatic op8(input logic s, input logic c, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] es, input logic ec, input logic eo);
    int e0;
    int nb;
    nb = 0;
    @(negedge clk);
    start = 1'b1; sub = s; cin = c; a = av; b = bv;
    @(posedge clk);
    #1;
    e0 = cyc;
    q8.push_back(mk(es, ec, eo, e0 + 4));
    for (int i = 0; i < 20 && q8.size() != 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; sub = ~s; cin = ~c; a = 8'h5A; b = 8'hC3;
      end
      #1;
      if (busy) nb++;
    end
    if (q8.size() != 0) begin
      check("w8_done_timeout", 32'(q8.size()), 32'd0);
      q8.delete();
    end
    check("w8_busy_cycles", 32'(nb), 32'd5);
  endtask

  logic [7:0] ta[14], tb_op[14];
  logic       ts[14], tc[14];
  logic [7:0] hs[3];
  logic       hc[3], ho[3];

  initial begin
    int e0;
    for (int k = 0; k < 14; k++) begin
      ta[k] = 8'(k * 17); tb_op[k] = 8'hA5; ts[k] = 1'b0; tc[k] = 1'b1;
    end
    ta[0]  = 8'h10; tb_op[0]  = 8'h20; ts[0]  = 1'b0; tc[0]  = 1'b0;
    ta[6]  = 8'h00; tb_op[6]  = 8'h01; ts[6]  = 1'b1; tc[6]  = 1'b0;
    ta[12] = 8'h40; tb_op[12] = 8'h40; ts[12] = 1'b0; tc[12] = 1'b1;
    hs[0] = 8'h30; hc[0] = 1'b0; ho[0] = 1'b0;
    hs[1] = 8'hFF; hc[1] = 1'b0; ho[1] = 1'b0;
    hs[2] = 8'h81; hc[2] = 1'b0; ho[2] = 1'b1;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_w2_busy", 32'(busy2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op8(1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op8(1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    op8(1'b0, 1'b1, 8'h3C, 8'h0A, 8'h47, 1'b0, 1'b0);
    op8(1'b1, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    op8(1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start held high: accepts at k = 0, 6, 12 only.
    @(negedge clk);
    e0 = 0;
    for (int k = 0; k < 14; k++) begin
      start = 1'b1; a = ta[k]; b = tb_op[k]; sub = ts[k]; cin = tc[k];
      @(posedge clk);
      #1;
      if (k == 0) e0 = cyc;
      if ((k % 6) == 0) q8.push_back(mk(hs[k/6], hc[k/6], ho[k/6], e0 + k + 4));
      @(negedge clk);
    end
    start = 1'b0;
    drain8();

    // Asynchronous reset in the 3rd RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 8'h9C; b = 8'h21;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_abort_sum", 32'(sum), 32'h000000D0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op8(1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // WIDTH=2 instance: 3 + 3 + 1 = 7.
    @(negedge clk);
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    q2.push_back(mk(8'h03, 1'b1, 1'b0, e0 + 1));
    @(negedge clk);
    start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
    for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
    #1;
    if (q2.size() != 0) begin
      check("w2_done_timeout", 32'(q2.size()), 32'd0);
      q2.delete();
    end

    repeat (3) @(negedge clk);
    check("queues_empty", 32'(q8.size() + q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Multi-cycle sequencer that computes a WIDTH-bit add or subtract using one shared 2-bit ripple slice: two full adders, each built from two half adders and an OR.
- Each RUN cycle processes 2 bits, LSB digit first. The slice's carry-out is registered and fed back as its carry-in on the next cycle.
- Provides a start/busy/done handshake so higher-level lab datapaths (ALU, accumulator) can request wide arithmetic without a wide adder.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be even and ≥2; odd values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b+cin; 1 = a−b (two's complement, cin ignored)
- cin  input  1  carry-in for add
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result
- cout  output  1  final carry-out (for sub: 1 = no borrow)
- ovf  output  1  signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand shift registers, carry register and digit counter cleared.
  - Reset mid-operation aborts; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1, latch opA=a, opB=(sub ? ~b : b), carry=(sub ? 1 : cin), cnt=0, and clear sum. Go to RUN.
  - sub, a, b and cin are don't-care after that edge.
- RUN (busy=1, one digit per edge):
  - Slice inputs: opA[1:0], opB[1:0], carry.
  - Slice outputs s1,s0 shift into sum from the MSB end: sum <= {s1,s0,sum[WIDTH-1:2]}.
  - Slice carry-out goes to carry. opA and opB shift right by 2.
  - Capture the slice's internal bit-1 carry-in (c1) when cnt=WIDTH/2−1, for ovf.
  - cnt increments. When cnt=WIDTH/2−1 on the edge, go to DONE.
- DONE (busy=1, done=1 for exactly one cycle):
  - cout=carry.
  - ovf = carry XOR captured c1, i.e. carry into MSB XOR carry out of MSB.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0.
  - done high during the cycle after edge E0+WIDTH/2 (WIDTH/2+1 edges after E0).
  - With start held high, throughput is one operation per WIDTH/2+2 cycles.
- Outputs hold:
  - sum, cout and ovf hold their values from DONE through IDLE until the next accepted start.
  - On start acceptance, sum, cout and ovf clear.
  - sum shows partial values during RUN; treat sum as valid only when done=1.
- start while busy (RUN or DONE) is ignored; nothing is queued.
- Arithmetic:
  - Modulo 2^WIDTH.
  - sub computes a + ~b + 1; cout=1 iff a≥b unsigned.
  - ovf uses signed two's-complement interpretation.
- Combinational slice only; all state is in the controller registers. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, add a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. done pulses exactly 5 edges after the start edge; busy high for 5 cycles.
- Add a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x3C, b=0x0A, cin=1 → sum=0x47, cout=0, ovf=0.
- sub=1, a=0x05, b=0x07, cin=1 (ignored) → sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- Start held high continuously with changing operands:
  - Pulses asserted mid-RUN and during DONE are ignored.
  - Result matches the operands present at the accepting edge.
  - Consecutive done pulses are 6 cycles apart.
- Assert rst_n=0 asynchronously (between edges) during the 3rd RUN cycle → all outputs 0 immediately, no done pulse. After release, a new add 0x12+0x34 → sum=0x46.
- WIDTH=2 instance: a=2'b11, b=2'b11, cin=1 → sum=2'b11, cout=1. done pulses on the 2nd edge after start.
